// File: rtl/commit_flush_ctrl_pkg.sv
// Shared types and constants for the branch-mispredict recovery controller.
// Holds the recovery FSM state encoding and the sequential-PC increment.
package commit_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/commit_flush_ctrl_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Latency: count reflects an increment one cycle after inc; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/commit_flush_ctrl.sv
// Mispredict recovery: drain stores, flush FLUSH_CYCLES cycles, then redirect fetch.
// Latency: redirect_valid FLUSH_CYCLES+1 cycles after commit; holds until redirect_ready.
module commit_flush_ctrl
    import commit_flush_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit_is_branch,
    input  logic             commit_prediction,
    input  logic             commit_result,
    input  logic [31:0]      committed_pc,
    input  logic [31:0]      commit_imm_se,
    input  logic             mem_busy,
    input  logic             redirect_ready,
    output logic             commit_hold,
    output logic             flush,
    output logic             fetch_stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       mispredict;
    logic       branch_inc;
    logic       mispredict_inc;

    assign mispredict     = commit_is_branch && (commit_prediction != commit_result);
    // Commit-side inputs are only meaningful while the pipeline is running.
    assign branch_inc     = (state == IDLE) && commit_is_branch;
    assign mispredict_inc = (state == IDLE) && mispredict;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            commit_hold    <= 1'b0;
            fetch_stall    <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        redirect_pc <= commit_result ? (committed_pc + commit_imm_se)
                                                     : (committed_pc + PC_INCR);
                        commit_hold <= 1'b1;
                        fetch_stall <= 1'b1;
                        if (mem_busy) begin
                            state <= WAIT_MEM;
                        end else begin
                            state     <= FLUSH;
                            flush     <= 1'b1;
                            flush_cnt <= 4'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                WAIT_MEM: begin
                    // Committed stores must land before the flush discards younger state.
                    if (!mem_busy) begin
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        flush_cnt <= 4'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state          <= REDIRECT;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        commit_hold    <= 1'b0;
                        fetch_stall    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_inc),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mispredict_inc),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_commit_flush_ctrl.sv
// Directed bench for commit_flush_ctrl: per-cycle vector table plus multi-cycle corner sequences.
module tb_commit_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_is_branch, commit_prediction, commit_result;
    logic [31:0] committed_pc, commit_imm_se;
    logic        mem_busy, redirect_ready;

    logic        commit_hold, flush, fetch_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    logic        commit_hold4, flush4, fetch_stall4, redirect_valid4;
    logic [31:0] redirect_pc4;
    logic [3:0]  branch_count4, mispredict_count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    commit_flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .commit_is_branch(commit_is_branch), .commit_prediction(commit_prediction),
        .commit_result(commit_result), .committed_pc(committed_pc),
        .commit_imm_se(commit_imm_se), .mem_busy(mem_busy), .redirect_ready(redirect_ready),
        .commit_hold(commit_hold), .flush(flush), .fetch_stall(fetch_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    commit_flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .commit_is_branch(commit_is_branch), .commit_prediction(commit_prediction),
        .commit_result(commit_result), .committed_pc(committed_pc),
        .commit_imm_se(commit_imm_se), .mem_busy(mem_busy), .redirect_ready(redirect_ready),
        .commit_hold(commit_hold4), .flush(flush4), .fetch_stall(fetch_stall4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .branch_count(branch_count4), .mispredict_count(mispredict_count4)
    );

    typedef struct {
        logic        rst, br, pred, res;
        logic [31:0] pc, imm;
        logic        busy, rdy;
        logic        e_hold, e_flush, e_vld;
        logic [31:0] e_pc;
        logic [15:0] e_bc, e_mc;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rst, br, pred, res, input logic [31:0] pc, imm,
                                input logic busy, rdy, e_hold, e_flush, e_vld,
                                input logic [31:0] e_pc, input logic [15:0] e_bc, e_mc);
        vec_t v;
        v.rst = rst; v.br = br; v.pred = pred; v.res = res; v.pc = pc; v.imm = imm;
        v.busy = busy; v.rdy = rdy; v.e_hold = e_hold; v.e_flush = e_flush;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, pred, res, input logic [31:0] pc, imm);
        commit_is_branch  = br;
        commit_prediction = pred;
        commit_result     = res;
        committed_pc      = pc;
        commit_imm_se     = imm;
    endtask

    initial begin
        reset = 1'b1; mem_busy = 1'b0; redirect_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // rst br pd rs pc imm busy rdy | hold flush vld rpc bc mc
        vecs[0]  = mk(1,0,0,0, 32'h0,        32'h0,        0,1, 0,0,0, 32'h0,   16'd0, 16'd0);
        vecs[1]  = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 0,0,0, 32'h0,   16'd0, 16'd0);
        vecs[2]  = mk(0,1,1,1, 32'h50,       32'h8,        0,1, 0,0,0, 32'h0,   16'd1, 16'd0);
        vecs[3]  = mk(0,1,0,0, 32'h60,       32'h8,        0,1, 0,0,0, 32'h0,   16'd2, 16'd0);
        vecs[4]  = mk(0,1,0,1, 32'h100,      32'h40,       0,1, 1,1,0, 32'h140, 16'd3, 16'd1);
        vecs[5]  = mk(0,1,0,1, 32'h300,      32'h40,       0,1, 1,1,0, 32'h140, 16'd3, 16'd1);
        vecs[6]  = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 1,0,1, 32'h140, 16'd3, 16'd1);
        vecs[7]  = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 0,0,0, 32'h140, 16'd3, 16'd1);
        vecs[8]  = mk(0,0,1,0, 32'h0,        32'h0,        0,1, 0,0,0, 32'h140, 16'd3, 16'd1);
        vecs[9]  = mk(0,1,0,1, 32'hFFFFFFF0, 32'h20,       0,1, 1,1,0, 32'h10,  16'd4, 16'd2);
        vecs[10] = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 1,1,0, 32'h10,  16'd4, 16'd2);
        vecs[11] = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 1,0,1, 32'h10,  16'd4, 16'd2);
        vecs[12] = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 0,0,0, 32'h10,  16'd4, 16'd2);
        vecs[13] = mk(0,1,0,1, 32'h1000,     32'hFFFFFFF0, 0,1, 1,1,0, 32'hFF0, 16'd5, 16'd3);
        vecs[14] = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 1,1,0, 32'hFF0, 16'd5, 16'd3);
        vecs[15] = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 1,0,1, 32'hFF0, 16'd5, 16'd3);
        vecs[16] = mk(0,0,0,0, 32'h0,        32'h0,        0,1, 0,0,0, 32'hFF0, 16'd5, 16'd3);

        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst; mem_busy = vecs[i].busy; redirect_ready = vecs[i].rdy;
            drive(vecs[i].br, vecs[i].pred, vecs[i].res, vecs[i].pc, vecs[i].imm);
            tick();
            chk($sformatf("vec%0d_hold", i),  {31'b0, commit_hold},    {31'b0, vecs[i].e_hold});
            chk($sformatf("vec%0d_stall", i), {31'b0, fetch_stall},    {31'b0, vecs[i].e_hold});
            chk($sformatf("vec%0d_flush", i), {31'b0, flush},          {31'b0, vecs[i].e_flush});
            chk($sformatf("vec%0d_vld", i),   {31'b0, redirect_valid}, {31'b0, vecs[i].e_vld});
            chk($sformatf("vec%0d_rpc", i),   redirect_pc,             vecs[i].e_pc);
            chk($sformatf("vec%0d_bc", i),    {16'b0, branch_count},   {16'b0, vecs[i].e_bc});
            chk($sformatf("vec%0d_mc", i),    {16'b0, mispredict_count}, {16'b0, vecs[i].e_mc});
        end

        // Taken mispredict while a store drains, then redirect backpressure.
        mem_busy = 1'b1; redirect_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h80);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait%0d_hold", i),  {31'b0, commit_hold}, 32'd1);
            chk($sformatf("wait%0d_flush", i), {31'b0, flush},       32'd0);
            if (i == 1) drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h4);
            if (i == 2) mem_busy = 1'b0;
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wait_bc", {16'b0, branch_count},     32'd6);
        chk("wait_mc", {16'b0, mispredict_count}, 32'd4);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wflush%0d", i), {31'b0, flush}, 32'd1);
            chk($sformatf("wflush%0d_vld", i), {31'b0, redirect_valid}, 32'd0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_vld", i),  {31'b0, redirect_valid}, 32'd1);
            chk($sformatf("bp%0d_rpc", i),  redirect_pc,             32'h204);
            chk($sformatf("bp%0d_hold", i), {31'b0, commit_hold},    32'd1);
            chk($sformatf("bp%0d_flush", i), {31'b0, flush},         32'd0);
            if (i == 4) redirect_ready = 1'b1;
            tick();
        end
        chk("bp_done_vld",  {31'b0, redirect_valid}, 32'd0);
        chk("bp_done_hold", {31'b0, commit_hold},    32'd0);
        chk("bp_done_rpc",  redirect_pc,             32'h204);

        // Reset during the second flush cycle.
        drive(1'b1, 1'b0, 1'b1, 32'h500, 32'h10);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("rst_pre_flush", {31'b0, flush}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_flush", {31'b0, flush},          32'd0);
        chk("rst_vld",   {31'b0, redirect_valid}, 32'd0);
        chk("rst_hold",  {31'b0, commit_hold},    32'd0);
        chk("rst_stall", {31'b0, fetch_stall},    32'd0);
        chk("rst_rpc",   redirect_pc,             32'h0);
        chk("rst_bc",    {16'b0, branch_count},   32'd0);
        chk("rst_mc",    {16'b0, mispredict_count}, 32'd0);
        tick();
        chk("rst_idle_hold", {31'b0, commit_hold}, 32'd0);
        chk("rst_idle_flush", {31'b0, flush},      32'd0);

        // Counter saturation on the narrow instance.
        drive(1'b1, 1'b1, 1'b1, 32'h700, 32'h8);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) chk("sat_pre15", {28'b0, branch_count4}, 32'd14);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("sat_bc4",  {28'b0, branch_count4},     32'd15);
        chk("sat_mc4",  {28'b0, mispredict_count4}, 32'd0);
        chk("sat_bc16", {16'b0, branch_count},      32'd20);
        chk("sat_flush4", {31'b0, flush4},          32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
